decp_sched: RTL

Scheduler for the receive-side de-cyclic-prefix buffer. It sits between frame synchronisation and the CP-removal FIFO that feeds the FFT, and sequences that FIFO per symbol. It counts incoming samples per symbol and drops the CP by withholding FIFO write enables. As soon as a complete N-sample body is buffered, it schedules FIFO reads toward the FFT under a ready handshake, so readout overlaps with the rest of the frame.

---
 rtl/decp_sched.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/decp_sched.sv
// Receive-side de-cyclic-prefix scheduler: drops the CP of each symbol by gating FIFO
// writes, then drains each fully buffered N-sample body toward the FFT under fft_rdy.
module decp_sched #(
    parameter int N       = 512,
    parameter int CP_LEN  = 32,
    parameter int MAX_SYM = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] sym_num,
    input  logic       di_vld,
    input  logic       fft_rdy,
    input  logic       fifo_empty,
    output logic       wr_en,
    output logic       rd_en,
    output logic       sym_start,
    output logic       sym_last,
    output logic [2:0] sym_idx,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {W_IDLE, W_CP, W_BODY} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_DONE} r_state_t;

    localparam logic [5:0] CP_LAST = 6'(CP_LEN - 1);
    localparam logic [9:0] N_LAST  = 10'(N - 1);

    w_state_t   w_state, w_next;
    r_state_t   r_state, r_next;
    logic [5:0] cp_cnt;
    logic [9:0] body_cnt;
    logic [9:0] rd_cnt;
    logic [3:0] wr_sym;
    logic [3:0] rd_sym;
    logic [3:0] avail;
    logic [3:0] avail_next;
    logic [2:0] num_q;
    logic       wr_last;

    logic sym_bad, accept, body_end, rd_end, frame_end;

    assign sym_bad   = (sym_num == 3'd0) || (int'(sym_num) > MAX_SYM);
    assign accept    = start && !busy && !sym_bad;
    assign body_end  = (w_state == W_BODY) && di_vld && (body_cnt == N_LAST);
    assign rd_en     = (r_state == R_READ) && fft_rdy;
    assign rd_end    = rd_en && (rd_cnt == N_LAST);
    assign frame_end = rd_end && (rd_sym + 4'd1 == {1'b0, num_q});
    assign sym_start = rd_en && (rd_cnt == 10'd0);
    assign sym_last  = frame_end;
    assign sym_idx   = rd_sym[2:0];

    // A symbol becomes readable when its last body write lands (wr_last is aligned
    // with that wr_en), so reads never overtake the FIFO write side.
    assign avail_next = avail + {3'b000, wr_last} - {3'b000, rd_end};

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if (accept) w_next = W_CP;
            W_CP:    if (di_vld && cp_cnt == CP_LAST) w_next = W_BODY;
            W_BODY:  if (body_end) w_next = (wr_sym + 4'd1 == {1'b0, num_q}) ? W_IDLE : W_CP;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE: if (busy && avail != 4'd0) r_next = R_READ;
            R_READ: begin
                if (frame_end)                 r_next = R_DONE;
                else if (rd_end)               r_next = (avail_next != 4'd0) ? R_READ : R_IDLE;
            end
            R_DONE:  r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state  <= W_IDLE;
            cp_cnt   <= '0;
            body_cnt <= '0;
            wr_sym   <= '0;
            num_q    <= '0;
            wr_en    <= 1'b0;
            wr_last  <= 1'b0;
        end else begin
            w_state <= w_next;
            wr_en   <= (w_state == W_BODY) && di_vld;
            wr_last <= body_end;
            if (accept) begin
                // A valid sample in the start cycle is already CP sample 0.
                num_q    <= sym_num;
                cp_cnt   <= di_vld ? 6'd1 : 6'd0;
                body_cnt <= '0;
                wr_sym   <= '0;
            end else begin
                if (w_state == W_CP && di_vld)
                    cp_cnt <= (cp_cnt == CP_LAST) ? 6'd0 : cp_cnt + 6'd1;
                if (w_state == W_BODY && di_vld)
                    body_cnt <= body_end ? 10'd0 : body_cnt + 10'd1;
                if (body_end)
                    wr_sym <= wr_sym + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            rd_cnt  <= '0;
            rd_sym  <= '0;
            avail   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            r_state <= r_next;
            done    <= frame_end;
            err     <= (start && (busy || sym_bad)) || (rd_en && fifo_empty);
            if (accept) begin
                rd_cnt <= '0;
                rd_sym <= '0;
                avail  <= '0;
                busy   <= 1'b1;
            end else begin
                avail <= avail_next;
                if (rd_en)
                    rd_cnt <= rd_end ? 10'd0 : rd_cnt + 10'd1;
                if (rd_end)
                    rd_sym <= rd_sym + 4'd1;
                if (r_state == R_DONE)
                    busy <= 1'b0;
            end
        end
    end

endmodule
